// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between WB and a buffered
// multiply/divide result stream, with a busy scoreboard and starvation stall request.
module regfile_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_we,
    input  logic [4:0]                   wb_addr,
    input  logic [31:0]                  wb_data,
    input  logic                         md_valid,
    output logic                         md_ready,
    input  logic [4:0]                   md_addr,
    input  logic [31:0]                  md_data,
    input  logic                         issue_valid,
    input  logic [4:0]                   issue_addr,
    input  logic [4:0]                   rs_addr,
    input  logic [4:0]                   rt_addr,
    output logic                         rs_busy,
    output logic                         rt_busy,
    output logic                         rf_we,
    output logic [4:0]                   rf_addr,
    output logic [31:0]                  rf_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         pipe_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STARVE_LIMIT+1);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   busy, busy_next;
    logic [SW-1:0] starve_cnt;
    logic          wb_live, empty, push, pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign wb_live    = wb_we && (wb_addr != 5'd0);
    assign empty      = (fifo_count == '0);
    assign md_ready   = rst_n && (fifo_count != CW'(DEPTH));
    assign push       = md_valid && md_ready;
    assign pop        = !wb_live && !empty;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    // Reset gates the write enable so nothing reaches the register file while held.
    assign rf_we      = rst_n && (wb_live || (pop && head_addr != 5'd0));
    assign rf_addr    = wb_live ? wb_addr : pop ? head_addr : 5'd0;
    assign rf_data    = wb_live ? wb_data : pop ? head_data : 32'd0;
    assign rs_busy    = busy[rs_addr];
    assign rt_busy    = busy[rt_addr];
    assign pipe_stall = (starve_cnt == SW'(STARVE_LIMIT));

    // Clear before set so an issue landing on the popped address keeps its bit.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head_addr] = 1'b0;
        if (issue_valid) busy_next[issue_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= md_addr;
            fifo_data[wr_ptr] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            busy       <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            busy       <= busy_next;
            if (pop || empty) starve_cnt <= '0;
            else if (wb_live && !pipe_stall) starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed plan steps then random traffic, checked every cycle
// against a queue-based model of the write-port arbiter.
module tb_regfile_wport_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 0, rst_n = 0;
    logic        wb_we = 0, md_valid = 0, issue_valid = 0;
    logic [4:0]  wb_addr = 0, md_addr = 0, issue_addr = 0, rs_addr = 0, rt_addr = 0;
    logic [31:0] wb_data = 0, md_data = 0;
    logic        md_ready, rs_busy, rt_busy, rf_we, pipe_stall;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    regfile_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .fifo_count(fifo_count), .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    bit [31:0]   busy_m;
    int          starve_m;
    bit          acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        qa.delete();
        qd.delete();
        busy_m = '0;
        starve_m = 0;
    endtask

    task automatic sample();
        bit wl;
        @(negedge clk);
        wl = wb_we && wb_addr != 0;
        if (wl) begin
            chk("rf_we", rf_we, 1); chk("rf_addr", rf_addr, wb_addr); chk("rf_data", rf_data, wb_data);
        end else if (qa.size() > 0) begin
            chk("rf_we", rf_we, qa[0] != 0); chk("rf_addr", rf_addr, qa[0]); chk("rf_data", rf_data, qd[0]);
        end else begin
            chk("rf_we", rf_we, 0); chk("rf_addr", rf_addr, 0); chk("rf_data", rf_data, 0);
        end
        chk("fifo_count", fifo_count, qa.size());
        chk("md_ready", md_ready, qa.size() < DEPTH);
        chk("rs_busy", rs_busy, busy_m[rs_addr]);
        chk("rt_busy", rt_busy, busy_m[rt_addr]);
        chk("pipe_stall", pipe_stall, starve_m == LIMIT);
    endtask

    task automatic edge_step();
        bit wl, pop, push;
        int sz;
        @(posedge clk);
        wl = wb_we && wb_addr != 0;
        sz = qa.size();
        pop = !wl && sz > 0;
        push = md_valid && sz < DEPTH;
        if (pop) begin
            busy_m[qa[0]] = 0;
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (issue_valid && issue_addr != 0) busy_m[issue_addr] = 1;
        if (push) begin
            qa.push_back(md_addr);
            qd.push_back(md_data);
        end
        if (pop || sz == 0) starve_m = 0;
        else if (wl && starve_m < LIMIT) starve_m++;
        acc = push;
        #1;
    endtask

    initial begin
        model_reset();
        // 1: reset held with traffic present
        wb_we = 1; wb_addr = 5; md_valid = 1; md_addr = 3;
        repeat (2) @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_md_ready", md_ready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_stall", pipe_stall, 0);
        wb_we = 0; md_valid = 0; rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rs_addr = 5'(i * 8 + 1); rt_addr = 5'(31 - i * 8);
            sample();
            chk("post_rst_md_ready", md_ready, 1);
            edge_step();
        end
        // 2: WB only
        wb_we = 1; wb_addr = 5; wb_data = 32'h55;
        sample();
        chk("wb_we", rf_we, 1); chk("wb_addr", rf_addr, 5); chk("wb_data", rf_data, 32'h55);
        edge_step();
        wb_addr = 0;
        sample();
        chk("wb_zero", rf_we, 0);
        edge_step();
        wb_we = 0;
        // 3: issue, push, write, clear
        issue_valid = 1; issue_addr = 8; rs_addr = 8;
        sample(); edge_step();
        issue_valid = 0; md_valid = 1; md_addr = 8; md_data = 32'hABCD;
        sample();
        chk("busy8_set", rs_busy, 1);
        edge_step();
        md_valid = 0;
        sample();
        chk("md_we", rf_we, 1); chk("md_addr", rf_addr, 8); chk("md_data", rf_data, 32'hABCD);
        edge_step();
        sample();
        chk("busy8_clr", rs_busy, 0);
        edge_step();
        // 4: fill while WB busy, then drain in order
        wb_we = 1; wb_addr = 3; wb_data = 32'h33;
        md_valid = 1; md_addr = 9; md_data = 1;
        sample(); edge_step();
        md_addr = 10; md_data = 2;
        sample(); edge_step();
        md_addr = 11; md_data = 3;
        sample();
        chk("full_count", fifo_count, 2); chk("full_ready", md_ready, 0);
        edge_step();
        wb_we = 0;
        sample();
        chk("drain1_addr", rf_addr, 9); chk("drain1_cnt", fifo_count, 2);
        edge_step();
        sample();
        chk("drain2_addr", rf_addr, 10); chk("drain2_cnt", fifo_count, 1);
        edge_step();
        md_valid = 0;
        sample();
        chk("drain3_addr", rf_addr, 11);
        edge_step();
        sample();
        chk("drained", fifo_count, 0);
        edge_step();
        // 5: starvation
        wb_we = 1; wb_addr = 7; md_valid = 1; md_addr = 13; md_data = 32'h13;
        sample(); edge_step();
        md_valid = 0;
        for (int i = 0; i < LIMIT; i++) begin
            sample();
            chk("no_stall_yet", pipe_stall, 0);
            edge_step();
        end
        wb_we = 0;
        sample();
        chk("stall_on", pipe_stall, 1); chk("stall_pop_we", rf_we, 1); chk("stall_pop_addr", rf_addr, 13);
        edge_step();
        sample();
        chk("stall_off", pipe_stall, 0);
        edge_step();
        // 6: set wins over pop-clear, push+pop keeps count, then reset mid-drain
        wb_we = 1; wb_addr = 3; issue_valid = 1; issue_addr = 12;
        md_valid = 1; md_addr = 12; md_data = 32'h12; rs_addr = 12;
        sample(); edge_step();
        wb_we = 0; md_addr = 14; md_data = 32'h14;
        sample();
        chk("pp_count_pre", fifo_count, 1); chk("pp_pop_addr", rf_addr, 12);
        edge_step();
        issue_valid = 0; wb_we = 1; md_addr = 15; md_data = 32'h15;
        sample();
        chk("pp_count_post", fifo_count, 1); chk("set_wins", rs_busy, 1);
        edge_step();
        wb_we = 0; md_valid = 0;
        sample(); edge_step();
        #2 rst_n = 0;
        #1;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_we", rf_we, 0);
        chk("midrst_busy", rs_busy, 0);
        chk("midrst_ready", md_ready, 0);
        model_reset();
        @(negedge clk);
        chk("midrst_we2", rf_we, 0);
        rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("after_rst_we", rf_we, 0);
            edge_step();
        end
        // random traffic
        acc = 0;
        for (int i = 0; i < 500; i++) begin
            wb_we = (starve_m == LIMIT) ? 1'b0 : ($urandom_range(0, 99) < 60);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            if (!md_valid || acc) begin
                md_valid = $urandom_range(0, 99) < 50;
                md_addr = 5'($urandom_range(0, 31));
                md_data = $urandom;
            end
            issue_valid = $urandom_range(0, 99) < 30;
            issue_addr = 5'($urandom_range(0, 31));
            rs_addr = 5'($urandom_range(0, 31));
            rt_addr = 5'($urandom_range(0, 31));
            sample();
            edge_step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
